// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared constants for the direct-mapped instruction cache
package icache_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int ICACHE_LINES = 128;
    localparam int ICACHE_IDX_W = $clog2(ICACHE_LINES);
    localparam int ICACHE_TAG_W = 32 - ICACHE_IDX_W - 2;

endpackage

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped one-word-line instruction cache with memory fill on miss
module icache
    import icache_pkg::*;
#(
    parameter int LINES = ICACHE_LINES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback,
    input  logic [31:0] IC_addr,
    input  logic        IC_addr_sgn,
    output logic [31:0] IC_ins,
    output logic        IC_ins_sgn,
    output logic [31:0] MC_addr,
    output logic        MC_req,
    input  logic        MC_done,
    input  logic [31:0] MC_ins
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 32 - IDX_W - 2;

    typedef enum logic {ST_IDLE, ST_MISS} state_t;

    state_t             state_q, state_d;
    logic               drop_q, drop_d;
    logic [29:0]        req_addr_q, req_addr_d;
    logic [31:0]        ins_q, ins_d;
    logic               pend_q, pend_d;
    logic               prev_sgn_q;
    logic [31:0]        mc_addr_q, mc_addr_d;
    logic               mc_req_q, mc_req_d;
    logic               fill_en;
    logic               deliver;
    logic               hit;

    logic [LINES-1:0]   valid_q;
    logic [TAG_W-1:0]   tag_arr  [LINES];
    logic [31:0]        data_arr [LINES];

    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic [IDX_W-1:0]   fill_idx;
    logic [TAG_W-1:0]   fill_tag;

    assign idx      = IC_addr[IDX_W+1:2];
    assign tag      = IC_addr[31:IDX_W+2];
    assign fill_idx = req_addr_q[IDX_W-1:0];
    assign fill_tag = req_addr_q[29:IDX_W];
    assign hit      = valid_q[idx] && (tag_arr[idx] == tag);

    // A pending pulse is held back one cycle after a delivered pulse, so two
    // responses never appear back to back; rollback kills it outright.
    assign deliver    = pend_q && !rollback && !prev_sgn_q;
    assign IC_ins_sgn = rdy && deliver;
    assign IC_ins     = ins_q;
    assign MC_addr    = mc_addr_q;
    assign MC_req     = mc_req_q;

    always_comb begin
        state_d    = state_q;
        drop_d     = drop_q;
        req_addr_d = req_addr_q;
        ins_d      = ins_q;
        pend_d     = pend_q;
        mc_addr_d  = mc_addr_q;
        mc_req_d   = mc_req_q;
        fill_en    = FALSE;

        if (rollback || deliver)
            pend_d = FALSE;

        case (state_q)
            ST_IDLE: begin
                if (IC_addr_sgn && !rollback) begin
                    req_addr_d = IC_addr[31:2];
                    if (hit) begin
                        ins_d  = data_arr[idx];
                        pend_d = TRUE;
                    end else begin
                        mc_addr_d = IC_addr & 32'hffff_fffc;
                        mc_req_d  = TRUE;
                        drop_d    = FALSE;
                        state_d   = ST_MISS;
                    end
                end
            end
            ST_MISS: begin
                if (rollback)
                    drop_d = TRUE;
                // The line is filled even when the response is dropped.
                if (MC_done) begin
                    fill_en  = TRUE;
                    mc_req_d = FALSE;
                    state_d  = ST_IDLE;
                    if (!drop_q && !rollback) begin
                        ins_d  = MC_ins;
                        pend_d = TRUE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            drop_q     <= FALSE;
            req_addr_q <= '0;
            ins_q      <= '0;
            pend_q     <= FALSE;
            prev_sgn_q <= FALSE;
            mc_addr_q  <= '0;
            mc_req_q   <= FALSE;
            valid_q    <= '0;
        end else begin
            prev_sgn_q <= IC_ins_sgn;
            if (rdy) begin
                state_q    <= state_d;
                drop_q     <= drop_d;
                req_addr_q <= req_addr_d;
                ins_q      <= ins_d;
                pend_q     <= pend_d;
                mc_addr_q  <= mc_addr_d;
                mc_req_q   <= mc_req_d;
                if (fill_en)
                    valid_q[fill_idx] <= TRUE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rdy && fill_en) begin
            tag_arr[fill_idx]  <= fill_tag;
            data_arr[fill_idx] <= MC_ins;
        end
    end

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - directed self-checking bench for icache
module tb_icache;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        rollback = 1'b0;
    logic [31:0] IC_addr = 32'h0;
    logic        IC_addr_sgn = 1'b0;
    logic [31:0] IC_ins;
    logic        IC_ins_sgn;
    logic [31:0] MC_addr;
    logic        MC_req;
    logic        MC_done = 1'b0;
    logic [31:0] MC_ins = 32'h0;

    int passed = 0;
    int total  = 0;

    icache dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .IC_addr(IC_addr), .IC_addr_sgn(IC_addr_sgn),
        .IC_ins(IC_ins), .IC_ins_sgn(IC_ins_sgn),
        .MC_addr(MC_addr), .MC_req(MC_req),
        .MC_done(MC_done), .MC_ins(MC_ins)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [31:0] addr);
        IC_addr     = addr;
        IC_addr_sgn = 1'b1;
        tick();
        IC_addr_sgn = 1'b0;
    endtask

    task automatic mem_done(input logic [31:0] data);
        MC_done = 1'b1;
        MC_ins  = data;
        tick();
        MC_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        total++; if (IC_ins_sgn !== 1'b0) $display("FAIL reset_sgn: got %b want 0", IC_ins_sgn); else passed++;
        total++; if (IC_ins !== 32'h0) $display("FAIL reset_ins: got %h want 0", IC_ins); else passed++;
        total++; if (MC_req !== 1'b0) $display("FAIL reset_req: got %b want 0", MC_req); else passed++;
        total++; if (MC_addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", MC_addr); else passed++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_cold_miss();
        request(32'h0000_0000);
        total++; if (MC_req !== 1'b1) $display("FAIL cold_req: got %b want 1", MC_req); else passed++;
        total++; if (MC_addr !== 32'h0) $display("FAIL cold_addr: got %h want 0", MC_addr); else passed++;
        total++; if (IC_ins_sgn !== 1'b0) $display("FAIL cold_early_sgn: got %b want 0", IC_ins_sgn); else passed++;
        tick(); tick();
        total++; if (MC_req !== 1'b1) $display("FAIL cold_req_held: got %b want 1", MC_req); else passed++;
        mem_done(32'h0000_0013);
        total++; if (IC_ins_sgn !== 1'b1) $display("FAIL cold_sgn: got %b want 1", IC_ins_sgn); else passed++;
        total++; if (IC_ins !== 32'h13) $display("FAIL cold_ins: got %h want 00000013", IC_ins); else passed++;
        total++; if (MC_req !== 1'b0) $display("FAIL cold_req_drop: got %b want 0", MC_req); else passed++;
        tick();
        total++; if (IC_ins_sgn !== 1'b0) $display("FAIL cold_pulse_len: got %b want 0", IC_ins_sgn); else passed++;
    endtask

    task automatic test_hit();
        request(32'h0000_0000);
        total++; if (MC_req !== 1'b0) $display("FAIL hit_req: got %b want 0", MC_req); else passed++;
        total++; if (IC_ins_sgn !== 1'b1) $display("FAIL hit_sgn: got %b want 1", IC_ins_sgn); else passed++;
        total++; if (IC_ins !== 32'h13) $display("FAIL hit_ins: got %h want 00000013", IC_ins); else passed++;
        tick();
        total++; if (IC_ins_sgn !== 1'b0) $display("FAIL hit_pulse_len: got %b want 0", IC_ins_sgn); else passed++;
    endtask

    task automatic test_conflict();
        request(32'h0000_0004);
        total++; if (MC_addr !== 32'h4) $display("FAIL conf_addr_a: got %h want 00000004", MC_addr); else passed++;
        mem_done(32'haaaa_0004);
        total++; if (IC_ins !== 32'haaaa_0004) $display("FAIL conf_ins_a: got %h want aaaa0004", IC_ins); else passed++;
        tick();
        request(32'h0000_0204);
        total++; if (MC_req !== 1'b1) $display("FAIL conf_req_b: got %b want 1", MC_req); else passed++;
        total++; if (MC_addr !== 32'h204) $display("FAIL conf_addr_b: got %h want 00000204", MC_addr); else passed++;
        mem_done(32'hbbbb_0204);
        total++; if (IC_ins !== 32'hbbbb_0204) $display("FAIL conf_ins_b: got %h want bbbb0204", IC_ins); else passed++;
        tick();
        request(32'h0000_0004);
        total++; if (MC_req !== 1'b1) $display("FAIL conf_req_again: got %b want 1", MC_req); else passed++;
        total++; if (IC_ins_sgn !== 1'b0) $display("FAIL conf_no_hit: got %b want 0", IC_ins_sgn); else passed++;
        mem_done(32'haaaa_0004);
        tick();
    endtask

    task automatic test_rollback_miss();
        request(32'h0000_0010);
        total++; if (MC_req !== 1'b1) $display("FAIL rbm_req: got %b want 1", MC_req); else passed++;
        tick();
        rollback = 1'b1;
        tick();
        rollback = 1'b0;
        total++; if (MC_req !== 1'b1) $display("FAIL rbm_req_held: got %b want 1", MC_req); else passed++;
        total++; if (MC_addr !== 32'h10) $display("FAIL rbm_addr_held: got %h want 00000010", MC_addr); else passed++;
        tick();
        mem_done(32'h1234_5678);
        total++; if (IC_ins_sgn !== 1'b0) $display("FAIL rbm_no_sgn: got %b want 0", IC_ins_sgn); else passed++;
        total++; if (MC_req !== 1'b0) $display("FAIL rbm_req_drop: got %b want 0", MC_req); else passed++;
        tick();
        total++; if (IC_ins_sgn !== 1'b0) $display("FAIL rbm_no_sgn_late: got %b want 0", IC_ins_sgn); else passed++;
        request(32'h0000_0010);
        total++; if (MC_req !== 1'b0) $display("FAIL rbm_hit_req: got %b want 0", MC_req); else passed++;
        total++; if (IC_ins_sgn !== 1'b1) $display("FAIL rbm_hit_sgn: got %b want 1", IC_ins_sgn); else passed++;
        total++; if (IC_ins !== 32'h1234_5678) $display("FAIL rbm_hit_ins: got %h want 12345678", IC_ins); else passed++;
        tick();
    endtask

    task automatic test_rdy_stall();
        request(32'h0000_0000);
        rdy = 1'b0;
        #1;
        total++; if (IC_ins_sgn !== 1'b0) $display("FAIL stall_sgn_0: got %b want 0", IC_ins_sgn); else passed++;
        tick();
        total++; if (IC_ins_sgn !== 1'b0) $display("FAIL stall_sgn_1: got %b want 0", IC_ins_sgn); else passed++;
        tick();
        total++; if (IC_ins_sgn !== 1'b0) $display("FAIL stall_sgn_2: got %b want 0", IC_ins_sgn); else passed++;
        tick();
        rdy = 1'b1;
        #1;
        total++; if (IC_ins_sgn !== 1'b1) $display("FAIL stall_resume_sgn: got %b want 1", IC_ins_sgn); else passed++;
        total++; if (IC_ins !== 32'h13) $display("FAIL stall_resume_ins: got %h want 00000013", IC_ins); else passed++;
        total++; if (MC_req !== 1'b0) $display("FAIL stall_req: got %b want 0", MC_req); else passed++;
        tick();
        total++; if (IC_ins_sgn !== 1'b0) $display("FAIL stall_pulse_len: got %b want 0", IC_ins_sgn); else passed++;
    endtask

    task automatic test_rollback_request();
        rollback = 1'b1;
        request(32'h0000_0020);
        rollback = 1'b0;
        #1;
        total++; if (MC_req !== 1'b0) $display("FAIL rbr_req: got %b want 0", MC_req); else passed++;
        total++; if (IC_ins_sgn !== 1'b0) $display("FAIL rbr_sgn: got %b want 0", IC_ins_sgn); else passed++;
        tick();
        total++; if (MC_req !== 1'b0) $display("FAIL rbr_req_late: got %b want 0", MC_req); else passed++;
        request(32'h0000_0020);
        total++; if (MC_req !== 1'b1) $display("FAIL rbd_req: got %b want 1", MC_req); else passed++;
        tick();
        rollback = 1'b1;
        mem_done(32'hcafe_0020);
        rollback = 1'b0;
        #1;
        total++; if (IC_ins_sgn !== 1'b0) $display("FAIL rbd_no_sgn: got %b want 0", IC_ins_sgn); else passed++;
        total++; if (MC_req !== 1'b0) $display("FAIL rbd_req_drop: got %b want 0", MC_req); else passed++;
        tick();
        request(32'h0000_0020);
        total++; if (MC_req !== 1'b0) $display("FAIL rbd_hit_req: got %b want 0", MC_req); else passed++;
        total++; if (IC_ins_sgn !== 1'b1) $display("FAIL rbd_hit_sgn: got %b want 1", IC_ins_sgn); else passed++;
        total++; if (IC_ins !== 32'hcafe_0020) $display("FAIL rbd_hit_ins: got %h want cafe0020", IC_ins); else passed++;
        tick();
    endtask

    task automatic test_back_to_back();
        request(32'h0000_0030);
        mem_done(32'h3030_3030);
        total++; if (IC_ins_sgn !== 1'b1) $display("FAIL b2b_fill_sgn: got %b want 1", IC_ins_sgn); else passed++;
        request(32'h0000_0030);
        total++; if (IC_ins_sgn !== 1'b0) $display("FAIL b2b_gap: got %b want 0", IC_ins_sgn); else passed++;
        total++; if (MC_req !== 1'b0) $display("FAIL b2b_req: got %b want 0", MC_req); else passed++;
        tick();
        total++; if (IC_ins_sgn !== 1'b1) $display("FAIL b2b_hit_sgn: got %b want 1", IC_ins_sgn); else passed++;
        total++; if (IC_ins !== 32'h3030_3030) $display("FAIL b2b_hit_ins: got %h want 30303030", IC_ins); else passed++;
        tick();
        total++; if (IC_ins_sgn !== 1'b0) $display("FAIL b2b_pulse_len: got %b want 0", IC_ins_sgn); else passed++;
    endtask

    task automatic test_reset_mid_miss();
        request(32'h0000_0040);
        total++; if (MC_req !== 1'b1) $display("FAIL rmm_req: got %b want 1", MC_req); else passed++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (MC_req !== 1'b0) $display("FAIL rmm_req_drop: got %b want 0", MC_req); else passed++;
        mem_done(32'h4040_4040);
        total++; if (IC_ins_sgn !== 1'b0) $display("FAIL rmm_late_sgn: got %b want 0", IC_ins_sgn); else passed++;
        total++; if (MC_req !== 1'b0) $display("FAIL rmm_late_req: got %b want 0", MC_req); else passed++;
        request(32'h0000_0000);
        total++; if (MC_req !== 1'b1) $display("FAIL rmm_cleared: got %b want 1", MC_req); else passed++;
        mem_done(32'h0000_0013);
        tick();
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_rollback_miss();
        test_rdy_stall();
        test_rollback_request();
        test_back_to_back();
        test_reset_mid_miss();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/icache.md
# icache

Direct-mapped instruction cache; the responder on the fetch-request interface driven by the instruction-fetch stage, and the initiator of word reads toward the memory controller. It accepts a one-cycle fetch pulse carrying a PC and returns the 32-bit instruction with a one-cycle valid pulse: a hit answers in 1 cycle, a miss fills from memory first. Pipeline rollback drops any in-flight response.

## Interface
- LINES, 128, number of one-word lines, power of two; IDX_W = log2(LINES)
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- rdy  input  1  global ready; low freezes all state
- rollback  input  1  pipeline flush; kills any pending response
- IC_addr  input  32  fetch PC, sampled only when IC_addr_sgn high
- IC_addr_sgn  input  1  fetch request pulse, one cycle
- IC_ins  output  32  instruction word, valid while IC_ins_sgn high
- IC_ins_sgn  output  1  response pulse, exactly one cycle per delivered request
- MC_addr  output  32  word address to memory controller
- MC_req  output  1  read request level, held until MC_done
- MC_done  input  1  memory controller completion pulse
- MC_ins  input  32  fetched word, valid with MC_done

## Operation
- Address split: offset = IC_addr[1:0] (ignored), index = IC_addr[IDX_W+1:2], tag = IC_addr[31:IDX_W+2].
- Storage per line: valid bit, tag, 32-bit data. Reset clears all valid bits; tag/data arrays not reset.
- States: IDLE, MISS.
- IDLE + IC_addr_sgn + !rollback: latch address into req_addr. Hit (valid && tag match) -> next cycle IC_ins = line data, IC_ins_sgn = 1, stay IDLE. Miss -> MC_addr = {IC_addr[31:2],2'b00}, MC_req = 1, drop = 0, go MISS.
- MISS: hold MC_req and MC_addr stable. On MC_done: write line (valid=1, tag, MC_ins); if !drop, drive IC_ins = MC_ins, IC_ins_sgn = 1 next cycle; MC_req = 0; go IDLE.
- rollback in MISS: set drop = 1; memory transaction not cancelled; line still filled on MC_done, no response.
- rollback in IDLE: any request in the same cycle is ignored; a hit response scheduled for the next cycle is suppressed.
- rollback together with MC_done: fill happens, response suppressed.
- IC_addr_sgn while in MISS: protocol violation (fetch stage has one outstanding request); ignored, no state change.
- rdy low: no state, array or output register changes; IC_ins_sgn held low for that cycle and the pending pulse resumes once rdy returns; MC_req holds its value.
- IC_ins_sgn is never high two consecutive cycles.

## Timing
- Reset values: IC_ins = 0, IC_ins_sgn = 0, MC_addr = 0, MC_req = 0, state = IDLE, drop = 0, all valid = 0.
- Hit latency: request at edge N -> IC_ins_sgn high during cycle N+1.
- Miss latency: MC_req high from cycle N+1; MC_done sampled at edge M -> IC_ins_sgn high during cycle M+1.
- Cache write on fill and tag read for a new request never collide: no request is accepted in MISS.
- Request in the cycle right after a fill to the same index hits.
- Reset mid-miss: returns to IDLE, MC_req drops next cycle; a late MC_done in IDLE is ignored.

## Structure
- Shared defines header: `TRUE/`FALSE, ICACHE_LINES, and derived ICACHE_IDX_W/ICACHE_TAG_W constants; state encodings stay local.
- Single module; arrays inline as reg vectors. No sub-module needed.

## Test plan
- Reset, request 0x00000000 -> MC_req with MC_addr 0; MC_done with 0x00000013 after 3 cycles -> IC_ins_sgn one cycle later, IC_ins = 0x00000013.
- Repeat request 0x00000000 -> no MC_req, IC_ins_sgn next cycle, IC_ins = 0x00000013.
- Conflict: fill 0x00000004, then request 0x00000204 (same index, LINES=128) -> miss, MC_addr = 0x00000204; then 0x00000004 misses again.
- Rollback two cycles into miss on 0x00000010 -> MC_req held until MC_done, no IC_ins_sgn; later request 0x00000010 hits.
- rdy low for 3 cycles at the edge a hit response is due -> IC_ins_sgn stays low, then appears for one cycle after rdy returns with the correct word.
- rollback coincident with request 0x00000020 -> no MC_req, no IC_ins_sgn; rollback coincident with MC_done -> line filled, no response.
